// File: rtl/addsub_seq64_if.sv
// Start/done handshake and result bus of the sequential 64-bit adder/subtractor.
interface addsub_seq64_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/addsub_seq64.sv
// Multi-cycle WIDTH-bit add/sub built from one SLICE-bit ripple slice, LSB slice first.
// Operands shift right through the slice; partial sums shift in from the top.
module addsub_seq64 #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 8
) (
  input  logic           clk,
  input  logic           rst,
  addsub_seq64_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              step;
  logic              commit;
  logic              last;

  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_nxt;
  logic              carry;
  logic [IDXW-1:0]   idx;

  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              busy_q;
  logic              done_q;

  logic [SLICE-1:0]  a_sl;
  logic [SLICE-1:0]  b_sl;
  logic [SLICE-1:0]  s_sl;
  logic [SLICE:0]    slice_res;
  logic              c_msb;

  // Shared ripple slice on the low bits of the shifting operand registers
  assign a_sl      = op_a[SLICE-1:0];
  assign b_sl      = op_b[SLICE-1:0];
  assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry);
  assign s_sl      = slice_res[SLICE-1:0];
  // Carry into the slice MSB, recovered from the sum bit
  assign c_msb     = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ s_sl[SLICE-1];
  assign acc_nxt   = (acc >> SLICE) | (WIDTH'(s_sl) << (WIDTH - SLICE));
  assign last      = (idx == IDXW'(NSLICE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
      if (load) begin
        op_a  <= bus.a;
        op_b  <= bus.b ^ {WIDTH{bus.sub}};
        carry <= bus.sub;
        idx   <= '0;
      end else if (step) begin
        op_a  <= op_a >> SLICE;
        op_b  <= op_b >> SLICE;
        acc   <= acc_nxt;
        carry <= slice_res[SLICE];
        idx   <= idx + IDXW'(1);
      end
      if (commit) begin
        sum_q  <= acc_nxt;
        cout_q <= slice_res[SLICE];
        ovf_q  <= slice_res[SLICE] ^ c_msb;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: doc/addsub_seq64.md
# addsub_seq64

Sequential 64-bit adder/subtractor that reuses one 8-bit ripple-carry slice over eight clock cycles, LSB slice first, under a start/done handshake. It complements the combinational adder path: it adds the subtraction direction (two's-complement a − b), area-minimal iteration and registered, flagged results. It sits in the datapath wherever a multi-cycle 64-bit add/sub is acceptable in exchange for one slice of adder hardware.

## Interface
- WIDTH, 64, operand/result width; must be a multiple of SLICE
- SLICE, 8, bits processed per cycle by the internal ripple-carry slice
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled when the block can accept (IDLE or DONE)
- sub  input  1  0 = a + b, 1 = a − b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while slices are being computed (RUN)
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result, registered, held until the next completion
- cout  output  1  carry out of MSB (for sub: 1 = no borrow, a ≥ b unsigned)
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b XOR {WIDTH{sub}}, carry ← sub, slice index ← 0; go to RUN. start=0 → stay.
- RUN: each cycle add slice [idx*SLICE +: SLICE] of latched A and B with the running carry; store the partial sum slice; carry ← slice carry out; idx ← idx+1. On the edge that computes slice WIDTH/SLICE−1: commit sum, cout and ovf to the output registers; go to DONE.
- ovf uses the carry into bit WIDTH−1, captured inside the final slice.
- DONE: done=1 for exactly this cycle. start=1 → accepted exactly as in IDLE (back-to-back operation) → RUN. Otherwise → IDLE.
- start, sub, a and b are ignored while in RUN. Operand changes after acceptance have no effect.
- sum, cout and ovf change only on the commit edge. They hold their value through IDLE, and through RUN of the next operation.
- Arithmetic is modulo 2^WIDTH; a − b = a + ~b + 1.

## Timing
- Reset (rst high at an edge): state ← IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; slice index and carry cleared. Reset during RUN or DONE aborts the operation; no done pulse is produced for it.
- Let E0 be the edge that samples an accepted start. busy is high after E0 through edge E0+WIDTH/SLICE−1, i.e. 8 cycles at default parameters.
- The commit happens at edge E0+WIDTH/SLICE (E0+8). done is high for the single cycle after that edge, with sum, cout and ovf already valid.
- Start-to-done latency: 8 edges. Minimum issue interval: 9 cycles when start is held high (accepted again in the DONE cycle).
- busy and done are never high together.

## Test plan
- Reset: assert rst mid-RUN, then hold start=0 → busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse occurs afterwards.
- Add with carry ripple: a=64'h00000000_FFFFFFFF, b=1, sub=0 → after 8 edges, done pulse; sum=64'h00000001_00000000, cout=0, ovf=0.
- Unsigned wrap and signed overflow:
  - a=64'hFFFF…FF, b=1, add → sum=0, cout=1, ovf=0.
  - a=64'h7FFF…FF, b=1, add → sum=64'h8000…00, cout=0, ovf=1.
- Subtract:
  - a=5, b=7, sub=1 → sum=64'hFFFF…FE, cout=0 (borrow), ovf=0.
  - a=64'h8000…00, b=1, sub=1 → sum=64'h7FFF…FF, cout=1, ovf=1.
- Handshake:
  - Toggle a, b, sub and pulse start during RUN → result reflects the originally latched operands.
  - Hold start high continuously with a new operand each DONE cycle → done pulses every 9 cycles with the correct results.
  - sum holds its value between operations.
